// File: rtl/uart_tx_serializer.sv
// Framed UART transmitter: valid/ready word in, start/data/[parity]/stop bits out on a registered tx line.
// Optional even-parity bit is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int LSB_FIRST    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [BIT_W-1:0]        r_bit;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic                    r_tx;
    logic                    r_done;

    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [BIT_W-1:0]        w_bit_nxt;
    logic [BIT_W-1:0]        w_idx;
    logic                    w_load;
    logic                    w_done_nxt;
    logic                    w_tx_nxt;
    logic                    w_cnt_last;

    assign w_cnt_last = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign w_load     = (r_state == S_IDLE) && tx_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_last ? '0 : r_cnt + CNT_W'(1);
        w_bit_nxt   = r_bit;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_bit_nxt = '0;
                if (tx_valid)
                    w_state_nxt = S_START;
            end
            S_START: begin
                if (w_cnt_last) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_cnt_last) begin
                    if (r_bit == BIT_W'(DATA_WIDTH - 1)) begin
                        w_bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_cnt_last) begin
                    w_state_nxt = S_STOP;
                    w_bit_nxt   = '0;
                end
            end
`endif
            // r_bit doubles as the stop-bit index here
            S_STOP: begin
                if (w_cnt_last) begin
                    if (r_bit == BIT_W'(STOP_BITS - 1)) begin
                        w_state_nxt = S_IDLE;
                        w_bit_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_bit_nxt = r_bit + BIT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_bit_nxt   = '0;
            end
        endcase
    end

    // Line level is derived from the next state so tx leaves a flop aligned with the state change.
    assign w_idx = (LSB_FIRST != 0) ? w_bit_nxt : BIT_W'(DATA_WIDTH - 1) - w_bit_nxt;

    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = r_shift[w_idx];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_nxt = ^r_shift;
`endif
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            if (w_load)
                r_shift <= tx_data;
            r_tx    <= w_tx_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign tx_ready = (r_state == S_IDLE) && !reset;
    assign busy     = (r_state != S_IDLE);
    assign tx       = r_tx;
    assign tx_done  = r_done;

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Parametrised UART transmit serializer. It accepts a parallel word through a valid/ready handshake and emits a complete asynchronous frame on a single line: start bit, data bits, optional parity bit, then stop bit(s). Bit timing comes from an internal baud counter. It sits between the host-side TX buffer and the tx pad, replacing the free-running parallel-in/serial-out shifter with a framed, flow-controlled transmitter.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 2.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.
LSB_FIRST, 1, 1 = data bit 0 sent first; 0 = data bit DATA_WIDTH-1 sent first.

Ports:
clk  input  1  single clock for all logic.
reset  input  1  synchronous, active-high reset.
tx_data  input  DATA_WIDTH  word to transmit; sampled only on handshake.
tx_valid  input  1  producer has a word available.
tx_ready  output  1  block can accept a word; high only in IDLE.
tx  output  1  serial line, registered; idle level 1.
busy  output  1  high from the cycle after acceptance until the frame completes.
tx_done  output  1  one-cycle pulse when the final stop bit has completed.

Behaviour:
- Reset (sampled on rising clk edge when reset=1): state=IDLE, tx=1, tx_ready=1, busy=0, tx_done=0. Baud counter, bit index and shift register are cleared.
- Reset has priority over every other event. Reset mid-frame aborts the frame. tx returns to 1 on the same edge, and the captured word is discarded.
- Handshake:
  - A transfer occurs on any edge where tx_valid=1 and tx_ready=1.
  - tx_data is latched into the shift register on that edge.
  - tx_valid is ignored while tx_ready=0; holding tx_valid high without a handshake has no effect.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: tx=1, tx_ready=1. On handshake, go to START. tx=0 is driven from the next edge, so first-bit latency is 1 cycle.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA:
    - DATA_WIDTH bits, each held for CLKS_PER_BIT cycles.
    - Bit order is set by LSB_FIRST.
    - The bit index counts 0..DATA_WIDTH-1. After the last bit, go to PARITY if it is enabled, otherwise to STOP.
  - PARITY: one bit for CLKS_PER_BIT cycles (see Optional Feature).
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the last cycle, go to IDLE; tx_done=1 in the first IDLE cycle only.
- Baud counter:
  - Width is $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit.
  - Reset to 0 on every state entry.
- Signal relationships:
  - busy = (state != IDLE).
  - tx_ready = (state == IDLE) && !reset.
- Back-to-back: a handshake in the same cycle that tx_done pulses is legal. The minimum frame period is (1 + DATA_WIDTH + P + STOP_BITS) * CLKS_PER_BIT + 1 cycles, where P is 1 if parity is enabled and 0 otherwise.
- tx_data changes after the handshake must not affect the frame in flight.
- tx is glitch-free, driven directly from a flop.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state is included. The parity bit is even parity, equal to the XOR of all DATA_WIDTH data bits, computed on the captured word. Frame length gains 1 bit.
- Undefined: the PARITY state and its logic are absent; DATA goes directly to STOP.
- The port list is identical in both builds.

Test Plan:
- Reset then idle, 10 cycles -> tx=1, tx_ready=1, busy=0, tx_done=0 throughout.
- Single frame (DATA_WIDTH=8, CLKS_PER_BIT=4, STOP_BITS=1, LSB_FIRST=1, no parity), send 0xA5.
  - Required tx bit sequence: 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - busy high for exactly 40 cycles; tx_done pulses once, 41 cycles after the handshake.
- Same configuration with UART_TX_PARITY_EN defined, send 0x07 -> parity bit=1 after the 8 data bits; frame is 44 cycles.
- Back-to-back: hold tx_valid=1 with 0x55 then 0x0F -> the second start bit begins exactly 1 cycle after the first frame's stop bit ends. tx_data changed mid-frame does not alter the frame.
- Reset asserted for 1 cycle at the 3rd data bit -> tx=1 on the next edge, state IDLE, no tx_done pulse. A new frame then transmits correctly.
- Parameter sweep, send 0x1E (9-bit value, only the low DATA_WIDTH bits sent):
  - DATA_WIDTH=5, STOP_BITS=2, LSB_FIRST=0, CLKS_PER_BIT=3 -> bit order 1,1,1,1,0; stop phase lasts 6 cycles.
  - DATA_WIDTH=9, STOP_BITS=1, LSB_FIRST=1, CLKS_PER_BIT=3 -> 9 data bits 0,1,1,1,1,0,0,0,0.
